bus_dispatch: RTL and testbench
===============================

Name: bus_dispatch

Overview:
Transmit-side counterpart of the receive bus master. Pops routed MIDI bytes from the central routing FIFO and writes each byte to the selected UART transmitters over a shared addr/data bus with one-hot write strobes. Each FIFO entry carries one data byte and a 4-bit destination mask. The block services every destination in the mask and skips busy ports, so one stalled output does not block the others.

Parameters:
NPORTS, 4, number of UART transmitters. Fixed at 4 in this revision; widths below assume 4.
DW, 8, data byte width.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
fifo_empty  input  1  routing FIFO empty flag
fifo_data  input  8  FIFO read data; valid the cycle after the edge that samples fifo_rd=1
fifo_mask  input  4  destination mask read with fifo_data; bit i selects transmitter i
fifo_rd  output  1  FIFO pop strobe, one cycle per entry
tx_busy  input  4  transmitter i cannot accept a byte while bit i=1
addr  output  4  transmitter address of the current write (0..3)
data  output  8  byte being written
bus_wr  output  4  one-hot write strobe; bit i writes data into transmitter i
drop  output  1  one-cycle pulse when an entry with mask 0000 is discarded
busy  output  1  high whenever state is not IDLE

Behaviour:
- All outputs are registered. Reset (asynchronous, any state): fifo_rd=0, addr=0, data=0x00, bus_wr=0000, drop=0, busy=0, pending mask cleared, state=IDLE. An entry in flight during reset is lost; it is not re-read.
- States: IDLE, WAIT, LATCH, SCAN, GAP.
- IDLE: if fifo_empty=0, set fifo_rd<=1 and go to WAIT. Otherwise stay in IDLE. fifo_rd is never asserted outside IDLE and never while fifo_empty=1.
- WAIT: set fifo_rd<=0 and go to LATCH. This covers the FIFO's 1-cycle read latency.
- LATCH: capture fifo_data into byte_reg and fifo_mask into pend.
  - If fifo_mask=0000: drop<=1 for one cycle, go to IDLE.
  - Otherwise go to SCAN.
- SCAN: select the lowest index i with pend[i]=1 and tx_busy[i]=0.
  - If one exists: bus_wr[i]<=1, addr<=i, data<=byte_reg, clear pend[i], go to GAP.
  - If none exists: stay in SCAN with bus_wr=0000.
  - tx_busy is sampled only in SCAN. No strobe is ever issued to a port whose tx_busy is 1 at that edge.
- GAP: bus_wr<=0000. The cycle gives transmitters time to raise tx_busy. Go to SCAN if pend≠0000, else to IDLE.
- bus_wr is high for exactly one cycle per destination and is at most one-hot. addr and data hold their last value when idle.
- Latency: with all destinations ready, the first bus_wr pulse is high in the 3rd cycle after the fifo_rd pulse. Each further destination adds 2 cycles.
- Throughput: single-destination entries take 5 cycles each (IDLE→WAIT→LATCH→SCAN→GAP→IDLE). A 4-destination broadcast takes 11 cycles.
- Each destination receives a given byte exactly once. Bytes to a given port keep FIFO order, because a new entry is popped only after pend reaches 0.
- If tx_busy changes in the same cycle as the SCAN decision, only the registered value sampled at that edge is used.
- No timeout: a permanently busy destination stalls the block in SCAN (busy=1). This is intentional, because MIDI transmitters always drain.

Test Plan:
- Reset with fifo_empty=0 asserted → all outputs 0 during reset. After release, first fifo_rd pulse on the first edge following release.
- Entry {0x90, 0001}, tx_busy=0000 → single fifo_rd pulse. bus_wr=0001, addr=0, data=0x90 for exactly one cycle, 3 cycles after fifo_rd. busy returns to 0.
- Entry {0xF8, 1111}, all ready → bus_wr sequence 0001, 0010, 0100, 1000 with addr 0..3, each separated by one 0000 cycle, data=0xF8 throughout, one fifo_rd only.
- Entry {0x45, 0011}, tx_busy=0001 for 10 cycles → bus_wr=0010 (addr=1) first. bus_wr=0001 only after tx_busy[0] falls. No fifo_rd meanwhile, even with fifo_empty=0.
- Entries {0x11, 0000} then {0x22, 0100} → drop pulses once and no bus_wr for 0x11. 0x22 is then written to port 2 (bus_wr=0100, addr=2).
- Reset asserted while in SCAN with port 3 busy → outputs 0 immediately. After release, pend is empty and the next FIFO entry is popped. The interrupted byte is never written.

Source files
------------

// File: rtl/bus_dispatch.sv
// bus_dispatch
// Transmit-side dispatcher. It pops routed MIDI bytes from the central
// routing FIFO and writes each byte to every UART transmitter selected by
// the entry's destination mask. Writes use a shared addr/data bus with
// one-hot write strobes. A busy transmitter is skipped and retried later,
// so one stalled port does not hold back the other destinations.
//
// Ports:
//   clk, reset  - system clock; asynchronous active-high reset
//   fifo_empty  - routing FIFO empty flag
//   fifo_data   - FIFO read data, valid the cycle after a sampled fifo_rd
//   fifo_mask   - destination mask read together with fifo_data
//   fifo_rd     - FIFO pop strobe, one cycle per entry
//   tx_busy     - per-transmitter busy flags
//   addr        - transmitter index of the current write
//   data        - byte being written
//   bus_wr      - one-hot write strobe
//   drop        - one-cycle pulse when an entry with an empty mask is discarded
//   busy        - high whenever the state machine is not idle
module bus_dispatch #(
  parameter int NPORTS = 4,
  parameter int DW     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DW-1:0]     fifo_data,
  input  logic [NPORTS-1:0] fifo_mask,
  output logic              fifo_rd,
  input  logic [NPORTS-1:0] tx_busy,
  output logic [3:0]        addr,
  output logic [DW-1:0]     data,
  output logic [NPORTS-1:0] bus_wr,
  output logic              drop,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LATCH,
    SCAN,
    GAP
  } state_t;

  state_t            state_reg, state_next;
  logic              fifo_rd_reg, fifo_rd_next;
  logic [3:0]        addr_reg, addr_next;
  logic [DW-1:0]     data_reg, data_next;
  logic [NPORTS-1:0] bus_wr_reg, bus_wr_next;
  logic              drop_reg, drop_next;
  logic              busy_reg, busy_next;
  logic [DW-1:0]     byte_reg, byte_next;
  logic [NPORTS-1:0] pend_reg, pend_next;

  // A port can be written when it still owes the byte and is not busy.
  logic [NPORTS-1:0] ready;
  logic [NPORTS-1:0] grant;
  logic [3:0]        sel_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_ready
      assign ready[gi] = pend_reg[gi] & ~tx_busy[gi];
    end
  endgenerate

  // Isolate the lowest set bit: the fixed-priority grant.
  assign grant = ready & (~ready + {{(NPORTS-1){1'b0}}, 1'b1});

  always_comb begin
    sel_idx = 4'd0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (ready[i]) sel_idx = 4'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      fifo_rd_reg <= 1'b0;
      addr_reg    <= 4'd0;
      data_reg    <= '0;
      bus_wr_reg  <= '0;
      drop_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      byte_reg    <= '0;
      pend_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      fifo_rd_reg <= fifo_rd_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      bus_wr_reg  <= bus_wr_next;
      drop_reg    <= drop_next;
      busy_reg    <= busy_next;
      byte_reg    <= byte_next;
      pend_reg    <= pend_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    fifo_rd_next = 1'b0;
    addr_next    = addr_reg;
    data_next    = data_reg;
    bus_wr_next  = '0;
    drop_next    = 1'b0;
    byte_next    = byte_reg;
    pend_next    = pend_reg;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_next = 1'b1;
          state_next   = WAIT;
        end
      end
      // Covers the FIFO's one-cycle read latency.
      WAIT: begin
        state_next = LATCH;
      end
      LATCH: begin
        byte_next = fifo_data;
        pend_next = fifo_mask;
        if (fifo_mask == '0) begin
          drop_next  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = SCAN;
        end
      end
      // Stays here until some pending port is ready; no timeout.
      SCAN: begin
        if (ready != '0) begin
          bus_wr_next = grant;
          addr_next   = sel_idx;
          data_next   = byte_reg;
          pend_next   = pend_reg & ~grant;
          state_next  = GAP;
        end
      end
      // Dead cycle so the written transmitter can raise tx_busy before the
      // next scan decision.
      GAP: begin
        state_next = (pend_reg != '0) ? SCAN : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy_next = (state_next != IDLE);

  assign fifo_rd = fifo_rd_reg;
  assign addr    = addr_reg;
  assign data    = data_reg;
  assign bus_wr  = bus_wr_reg;
  assign drop    = drop_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_bus_dispatch.sv
// Testbench for bus_dispatch. A small FIFO model feeds the DUT. Directed
// scenarios push entries and expected bus writes into a scoreboard queue.
// A monitor pops and compares on every observed write strobe.
module tb_bus_dispatch;

  logic       clk;
  logic       reset;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic [3:0] fifo_mask;
  logic       fifo_rd;
  logic [3:0] tx_busy;
  logic [3:0] addr;
  logic [7:0] data;
  logic [3:0] bus_wr;
  logic       drop;
  logic       busy;

  bus_dispatch #(.NPORTS(4), .DW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_mask  (fifo_mask),
    .fifo_rd    (fifo_rd),
    .tx_busy    (tx_busy),
    .addr       (addr),
    .data       (data),
    .bus_wr     (bus_wr),
    .drop       (drop),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- FIFO model ----------------
  logic [7:0] mem_d [0:31];
  logic [3:0] mem_m [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd) begin
      checks++;
      if (rd_ptr == wr_ptr) begin
        errors++;
        $display("FAIL fifo_rd_when_empty: fifo_rd=1 with fifo_empty=1 at cycle %0d", cyc);
      end else begin
        fifo_data <= mem_d[rd_ptr];
        fifo_mask <= mem_m[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic [3:0] m);
    mem_d[wr_ptr] = d;
    mem_m[wr_ptr] = m;
    wr_ptr++;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int         port;
    logic [7:0] byte_val;
    int         offset;   // cycles after the latest fifo_rd, -1 = don't care
  } exp_t;

  exp_t exp_q[$];

  task automatic expect_wr(input int port, input logic [7:0] b, input int off);
    exp_t e;
    e.port = port;
    e.byte_val = b;
    e.offset = off;
    exp_q.push_back(e);
  endtask

  int         cyc = 0;
  logic [3:0] busy_at_edge = 4'b0000;
  int         last_rd = -100;
  int         rd_gap = 0;
  int         rd_count = 0;
  int         drop_count = 0;
  logic [3:0] prev_wr = 4'b0000;

  always @(posedge clk) begin
    cyc++;
    busy_at_edge = tx_busy;
  end

  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] want_wr;
    if (fifo_rd) begin
      rd_gap  = cyc - last_rd;
      last_rd = cyc;
      rd_count++;
    end
    if (drop) drop_count++;
    if (bus_wr != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: bus_wr=%b addr=%0d data=%02h, no write expected", bus_wr, addr, data);
      end else begin
        e = exp_q.pop_front();
        want_wr = 4'b0001 << e.port;
        if (bus_wr !== want_wr || addr !== 4'(e.port) || data !== e.byte_val ||
            (e.offset >= 0 && (cyc - last_rd) != e.offset)) begin
          errors++;
          $display("FAIL write: got bus_wr=%b addr=%0d data=%02h delay=%0d, want bus_wr=%b addr=%0d data=%02h delay=%0d",
                   bus_wr, addr, data, cyc - last_rd, want_wr, e.port, e.byte_val, e.offset);
        end else begin
          $display("write port=%0d data=%02h delay=%0d", e.port, data, cyc - last_rd);
        end
      end
      checks++;
      if ((bus_wr & busy_at_edge) != 4'b0000) begin
        errors++;
        $display("FAIL write_to_busy: bus_wr=%b while tx_busy=%b", bus_wr, busy_at_edge);
      end
      checks++;
      if (prev_wr != 4'b0000) begin
        errors++;
        $display("FAIL no_gap: bus_wr=%b follows bus_wr=%b, want a 0000 cycle between", bus_wr, prev_wr);
      end
    end
    prev_wr = bus_wr;
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end else begin
      $display("check %s = %0d", name, act);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_fifo_rd"}, int'(fifo_rd), 0);
    check({name, "_addr"},    int'(addr),    0);
    check({name, "_data"},    int'(data),    0);
    check({name, "_bus_wr"},  int'(bus_wr),  0);
    check({name, "_drop"},    int'(drop),    0);
    check({name, "_busy"},    int'(busy),    0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || !fifo_empty || fifo_rd) && n < 80);
    checks++;
    if (busy || !fifo_empty || fifo_rd) begin
      errors++;
      $display("FAIL %s_timeout: still busy=%0d fifo_empty=%0d after %0d cycles, want idle", name, busy, fifo_empty, n);
    end
  endtask

  int r0, d0;

  initial begin
    reset   = 1'b1;
    tx_busy = 4'b0000;

    // Reset with a non-empty FIFO, then the first single-destination entry.
    push(8'h90, 4'b0001);
    expect_wr(0, 8'h90, 3);
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("first_rd_after_release", int'(fifo_rd), 1);
    wait_idle("single");
    check("single_rd_count", rd_count, 1);
    check("single_busy_after", int'(busy), 0);

    // Broadcast to all four ports.
    r0 = rd_count;
    push(8'hF8, 4'b1111);
    expect_wr(0, 8'hF8, 3);
    expect_wr(1, 8'hF8, 5);
    expect_wr(2, 8'hF8, 7);
    expect_wr(3, 8'hF8, 9);
    wait_idle("broadcast");
    check("broadcast_rd_count", rd_count - r0, 1);

    // Back-to-back single-destination entries: 5 cycles per entry.
    push(8'h31, 4'b0010);
    push(8'h32, 4'b0100);
    expect_wr(1, 8'h31, 3);
    expect_wr(2, 8'h32, 3);
    wait_idle("back_to_back");
    check("back_to_back_rd_gap", rd_gap, 5);

    // Port 0 busy for 10 cycles: port 1 served first, no pop while stalled.
    tx_busy = 4'b0001;
    r0 = rd_count;
    push(8'h45, 4'b0011);
    push(8'h46, 4'b0001);
    expect_wr(1, 8'h45, 3);
    expect_wr(0, 8'h45, -1);
    expect_wr(0, 8'h46, 3);
    repeat (10) @(negedge clk);
    check("stall_rd_count", rd_count - r0, 1);
    check("stall_busy", int'(busy), 1);
    tx_busy = 4'b0000;
    wait_idle("stall");
    check("stall_rd_total", rd_count - r0, 2);

    // Empty-mask entry is dropped, then the next entry goes to port 2.
    d0 = drop_count;
    push(8'h11, 4'b0000);
    push(8'h22, 4'b0100);
    expect_wr(2, 8'h22, 3);
    wait_idle("drop");
    check("drop_count", drop_count - d0, 1);
    check("drop_addr_held", int'(addr), 2);
    check("drop_data_held", int'(data), 8'h22);

    // Reset while stalled in SCAN on busy port 3: the byte is lost.
    tx_busy = 4'b1000;
    push(8'h77, 4'b1000);
    push(8'h78, 4'b0001);
    expect_wr(0, 8'h78, 3);
    repeat (6) @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    wait_idle("after_reset");
    check("after_reset_addr", int'(addr), 0);
    tx_busy = 4'b0000;
    repeat (4) @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
